// File: rtl/shifter_op_scheduler.sv
// rtl/shifter_op_scheduler.sv - round-robin scheduler sharing one shift/double datapath between two requesters
//
// Accepts one operation at a time from two requesters, drives the shared
// datapath's operand/opcode registers, waits LAT cycles for the datapath
// result, then returns it for one cycle tagged with the owning requester.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req0_valid/data/ctrl/ready    requester 0 command handshake
//   req1_valid/data/ctrl/ready    requester 1 command handshake
//   sh_data_in, sh_control        registered datapath operand and opcode
//   sh_data_out                   datapath result
//   rsp_valid, rsp_id, rsp_data   one-cycle result strobe, owner, captured result
//   busy                          high whenever an operation is in flight
//   grant_cnt0, grant_cnt1        wrapping per-requester accept counters

module shifter_op_scheduler #(
    parameter int DATA_W = 4,
    parameter int CTRL_W = 3,
    parameter int LAT    = 2,   // legal range 1..15
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [CTRL_W-1:0] req0_ctrl,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              req1_ready,
    output logic [DATA_W-1:0] sh_data_in,
    output logic [CTRL_W-1:0] sh_control,
    input  logic [DATA_W-1:0] sh_data_out,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    localparam int                WAIT_W   = 4;
    localparam logic [WAIT_W-1:0] LAT_LOAD = WAIT_W'(LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              rr_ptr;
    logic              owner_id;
    logic              grant_id;
    logic              accept;
    logic              wait_done;
    logic [WAIT_W-1:0] wait_cnt;

    // Grant selection. With a single valid requester it wins outright;
    // with both, the round-robin pointer decides. Ready is also held low
    // while reset is asserted so nothing looks accepted during reset.
    always_comb begin
        grant_id   = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        req0_ready = (state == S_IDLE) && !rst && req0_valid && !grant_id;
        req1_ready = (state == S_IDLE) && !rst && req1_valid && grant_id;
        accept     = req0_ready || req1_ready;
        wait_done  = (wait_cnt == WAIT_W'(1));
    end

    always_comb begin
        state_nxt = state;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_done) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= 1'b0;
            owner_id   <= 1'b0;
            wait_cnt   <= '0;
            sh_data_in <= '0;
            sh_control <= '0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sh_data_in <= grant_id ? req1_data : req0_data;
                        sh_control <= grant_id ? req1_ctrl : req0_ctrl;
                        owner_id   <= grant_id;
                        // Last winner drops to lowest priority.
                        rr_ptr     <= ~grant_id;
                        wait_cnt   <= LAT_LOAD;
                        if (grant_id) begin
                            grant_cnt1 <= grant_cnt1 + CNT_W'(1);
                        end else begin
                            grant_cnt0 <= grant_cnt0 + CNT_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - WAIT_W'(1);
                    // Final WAIT cycle: the datapath result is valid now.
                    if (wait_done) begin
                        rsp_data <= sh_data_out;
                        rsp_id   <= owner_id;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
